vicuna_cluster_ctrl: RTL and testbench
======================================

// Module: vicuna_cluster_ctrl
// PURPOSE
// TL-UL device on the management peripherals crossbar that sequences the Vicuna worker cores.
// Holds each core in reset, programs its boot address, releases it on request and captures its
// completion. It sits directly upstream of the rv_core_vicuna instances: it drives their reset
// and boot address. It raises one interrupt to the management core when a core finishes.
// PARAMETERS
// NumCores         2         number of Vicuna cores sequenced (1..8)
// ResetHoldCycles  16        cycles core reset stays asserted after START before release (>=2)
// BootAddrDefault  32'h0     boot address of every core after reset
// PORTS
// clk_i             in   1               system clock
// rst_i             in   1               synchronous reset, active-high
// tl_i              in   tl_h2d_t        TL-UL request from management peripherals xbar
// tl_o              out  tl_d2h_t        TL-UL response
// core_rst_no       out  NumCores        per-core reset to rv_core_vicuna, active-low
// core_boot_addr_o  out  NumCores x 32   per-core boot address, stable while core runs
// core_done_i       in   NumCores        per-core completion pulse (1 cycle), from core GPIO/CSR
// irq_o             out  1               level interrupt: |(DONE_FLAGS & IRQ_EN)
// BEHAVIOUR
// Reset (rst_i sampled high at posedge): every core in IDLE, core_rst_no=0, boot addr=BootAddrDefault,
//   DONE_FLAGS=0, IRQ_EN=0, irq_o=0, d_valid=0. a_ready=0 while rst_i high.
// Register map (word offsets):
//   0x00 CTRL, write-only: bit i START core i; bit 16+i STOP core i; reads 0.
//   0x04 STATUS, RO: bits [2i+1:2i] state of core i (IDLE=0, HOLD=1, RUN=2, DONE=3).
//   0x08 DONE_FLAGS, W1C: bit i sticky done.
//   0x0C IRQ_EN, RW.
//   0x10+4i BOOT_ADDR[i], RW.
// TL-UL:
//   - One outstanding request; a_ready = !d_valid_q. Response registered: d_valid the cycle after
//     accept, held until d_ready.
//   - Get -> AccessAckData. PutFull/PutPartial -> AccessAck. d_source/d_size echo the request.
//   - d_error=1 and no side effect for: unmapped offset; a_mask != 4'hF on a write; BOOT_ADDR[i]
//     write while core i is in HOLD or RUN. Error responses return d_data=0.
//   - Integrity fields on d_user are generated as everywhere else on the crossbar.
// Per-core FSM:
//   IDLE -START-> HOLD
//   HOLD: counter counts ResetHoldCycles cycles -> RUN
//   RUN: core_done_i -> DONE, sets DONE_FLAGS[i]
//   DONE -START-> HOLD
//   any state -STOP-> IDLE (counter cleared)
//   START while in HOLD or RUN is ignored; no error.
//   core_rst_no[i]=1 only in RUN. The change is registered and takes effect the cycle after the
//   state transition.
// Simultaneous events:
//   - START and STOP in one write: STOP wins.
//   - STOP write and core_done_i in the same cycle: IDLE, flag not set.
//   - W1C of DONE_FLAGS[i] in the same cycle as a new done: flag stays 1.
//   - core_done_i outside RUN is ignored.
// Reset mid-transaction: pending response dropped, d_valid=0 next cycle, all cores IDLE.
// STRUCTURE
// vicuna_cluster_ctrl_pkg: register offsets, core_state_e enum, CTRL bit positions.
// Sub-module vicuna_core_seq: one per core via generate. Contains the FSM, the hold counter
// ($clog2(ResetHoldCycles+1) bits) and the core_rst_no flop. Top level holds the TL-UL decode
// and the register file.
// TESTING
// 1. Reset, read STATUS -> 0. core_rst_no=0. Read BOOT_ADDR0 -> BootAddrDefault.
// 2. Write BOOT_ADDR1=0x0001_0000, then CTRL=0x2 -> core_rst_no[1] rises exactly
//    ResetHoldCycles+1 cycles after write accept. STATUS[3:2]=2.
// 3. Core0 RUN, pulse core_done_i[0] with IRQ_EN=1 -> core_rst_no[0]=0, DONE_FLAGS=1, irq_o=1.
//    Write DONE_FLAGS=1 -> irq_o=0.
// 4. Write BOOT_ADDR0 while core0 in RUN -> d_error=1, readback unchanged.
//    Write with a_mask=4'h3 -> d_error=1.
// 5. CTRL=0x0001_0001 -> core stays/goes IDLE. STOP during HOLD -> IDLE, core_rst_no never rises.
// 6. Hold d_ready=0 for 5 cycles -> d_valid held, a_ready=0, second request accepted only after
//    handshake. Unmapped 0x40 -> d_error=1.

Source files
------------

// File: rtl/vicuna_cluster_ctrl_pkg.sv
// Shared types and constants for the Vicuna cluster controller: register map,
// per-core sequencer states, TL-UL opcodes and response integrity helper.
package vicuna_cluster_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } core_state_e;

    // Word indices (byte offset >> 2); BOOT_ADDR[i] lives at BOOT_IDX + i.
    localparam logic [9:0] CTRL_IDX   = 10'd0;
    localparam logic [9:0] STATUS_IDX = 10'd1;
    localparam logic [9:0] DONE_IDX   = 10'd2;
    localparam logic [9:0] IRQ_EN_IDX = 10'd3;
    localparam logic [9:0] BOOT_IDX   = 10'd4;

    localparam int unsigned CTRL_START_LSB = 0;
    localparam int unsigned CTRL_STOP_LSB  = 16;

    localparam logic [2:0] TL_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_GET         = 3'd4;
    localparam logic [2:0] TL_ACK         = 3'd0;
    localparam logic [2:0] TL_ACK_DATA    = 3'd1;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    // 7-bit check code: XOR-fold of the zero-extended word into 7-bit lanes.
    function automatic logic [6:0] intg_code(input logic [31:0] data);
        logic [34:0] ext;
        ext = {3'b000, data};
        return ext[6:0] ^ ext[13:7] ^ ext[20:14] ^ ext[27:21] ^ ext[34:28];
    endfunction

endpackage

// File: rtl/vicuna_cluster_ctrl_if.sv
// TL-UL channel A/D bundle between the management crossbar and the cluster controller.
interface vicuna_cluster_ctrl_if;
    logic                                a_valid;
    logic [2:0]                          a_opcode;
    logic [1:0]                          a_size;
    logic [7:0]                          a_source;
    logic [31:0]                         a_address;
    logic [3:0]                          a_mask;
    logic [31:0]                         a_data;
    logic                                a_ready;
    logic                                d_valid;
    logic [2:0]                          d_opcode;
    logic [1:0]                          d_size;
    logic [7:0]                          d_source;
    logic [31:0]                         d_data;
    logic                                d_error;
    vicuna_cluster_ctrl_pkg::tl_d_user_t d_user;
    logic                                d_ready;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error, d_user
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error, d_user
    );
endinterface

// File: rtl/vicuna_core_seq.sv
// Per-core sequencer: IDLE/HOLD/RUN/DONE state machine, reset hold counter and the
// registered active-low core reset.
module vicuna_core_seq
    import vicuna_cluster_ctrl_pkg::*;
#(
    parameter int unsigned ResetHoldCycles = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        done_i,
    output core_state_e state_o,
    output logic        done_evt_o,
    output logic        rst_no
);
    localparam int unsigned    CntW    = $clog2(ResetHoldCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(ResetHoldCycles - 1);

    core_state_e     state_r, state_d;
    logic [CntW-1:0] cnt_r, cnt_d;
    logic            rst_n_r;

    // Next state; STOP overrides everything and suppresses a coincident done.
    always_comb begin
        state_d    = state_r;
        cnt_d      = cnt_r;
        done_evt_o = 1'b0;
        if (stop_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        state_d = state_r;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == CntLast) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_r + CntW'(1);
                    end
                end
                ST_RUN: begin
                    if (done_i) begin
                        state_d    = ST_DONE;
                        done_evt_o = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and reset flop; the reset output lags the state by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            rst_n_r <= 1'b0;
        end else begin
            state_r <= state_d;
            cnt_r   <= cnt_d;
            rst_n_r <= (state_r == ST_RUN);
        end
    end

    assign state_o = state_r;
    assign rst_no  = rst_n_r;

endmodule

// File: rtl/vicuna_cluster_ctrl.sv
// TL-UL device that sequences the Vicuna worker cores: register file, decode,
// one-outstanding response path and the done interrupt.
module vicuna_cluster_ctrl
    import vicuna_cluster_ctrl_pkg::*;
#(
    parameter int unsigned NumCores        = 2,
    parameter int unsigned ResetHoldCycles = 16,
    parameter logic [31:0] BootAddrDefault = 32'h0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    vicuna_cluster_ctrl_if.slave       tl,
    output logic [NumCores-1:0]        core_rst_no,
    output logic [NumCores-1:0][31:0]  core_boot_addr_o,
    input  logic [NumCores-1:0]        core_done_i,
    output logic                       irq_o
);
    core_state_e               state_s [NumCores];
    logic [NumCores-1:0]       start_s, stop_s, done_evt_s, boot_sel_s, boot_busy_s, w1c_s;
    logic [NumCores-1:0][31:0] boot_addr_r;
    logic [NumCores-1:0]       done_flags_r, done_flags_d, irq_en_r, irq_en_d;
    logic                      irq_r;
    logic                      accept_s, is_read_s, is_write_s, map_hit_s, err_s, wr_ok_s;
    logic [9:0]                word_idx_s, boot_idx_s;
    logic [31:0]               status_s, rdata_s;
    logic                      d_valid_r, d_error_r;
    logic [2:0]                d_opcode_r;
    logic [1:0]                d_size_r;
    logic [7:0]                d_source_r;
    logic [31:0]               d_data_r;
    logic                      unused_s;

    assign accept_s   = tl.a_valid && tl.a_ready;
    assign word_idx_s = tl.a_address[11:2];
    assign boot_idx_s = word_idx_s - BOOT_IDX;
    assign is_read_s  = (tl.a_opcode == TL_GET);
    assign is_write_s = (tl.a_opcode == TL_PUT_FULL) || (tl.a_opcode == TL_PUT_PARTIAL);
    assign wr_ok_s    = accept_s && is_write_s && !err_s;
    assign unused_s   = ^{tl.a_address[31:12], tl.a_address[1:0]};
    assign status_s[31:2*NumCores] = '0;

    for (genvar g = 0; g < NumCores; g++) begin : gen_core
        assign boot_sel_s[g]  = (word_idx_s >= BOOT_IDX) && (boot_idx_s == 10'(g));
        assign boot_busy_s[g] = boot_sel_s[g] && ((state_s[g] == ST_HOLD) || (state_s[g] == ST_RUN));
        assign start_s[g]     = wr_ok_s && (word_idx_s == CTRL_IDX) && tl.a_data[CTRL_START_LSB + g];
        assign stop_s[g]      = wr_ok_s && (word_idx_s == CTRL_IDX) && tl.a_data[CTRL_STOP_LSB + g];
        assign status_s[2*g +: 2] = state_s[g];

        vicuna_core_seq #(
            .ResetHoldCycles(ResetHoldCycles)
        ) u_seq (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .start_i    (start_s[g]),
            .stop_i     (stop_s[g]),
            .done_i     (core_done_i[g]),
            .state_o    (state_s[g]),
            .done_evt_o (done_evt_s[g]),
            .rst_no     (core_rst_no[g])
        );
    end

    // Address decode, read mux and error classification for the request on channel A.
    always_comb begin
        rdata_s   = 32'h0;
        map_hit_s = 1'b0;
        case (word_idx_s)
            CTRL_IDX:   map_hit_s = 1'b1;
            STATUS_IDX: begin map_hit_s = 1'b1; rdata_s = status_s; end
            DONE_IDX:   begin map_hit_s = 1'b1; rdata_s = 32'(done_flags_r); end
            IRQ_EN_IDX: begin map_hit_s = 1'b1; rdata_s = 32'(irq_en_r); end
            default: begin
                map_hit_s = |boot_sel_s;
                for (int i = 0; i < NumCores; i++) begin
                    if (boot_sel_s[i]) begin
                        rdata_s = boot_addr_r[i];
                    end else begin
                        rdata_s = rdata_s;
                    end
                end
            end
        endcase
        err_s = !map_hit_s || !(is_read_s || is_write_s) ||
                (is_write_s && ((tl.a_mask != 4'hF) || (|boot_busy_s)));
    end

    // Next values of the done flags (a new done beats a same-cycle clear) and IRQ enables.
    always_comb begin
        if (wr_ok_s && (word_idx_s == DONE_IDX)) begin
            w1c_s = tl.a_data[NumCores-1:0];
        end else begin
            w1c_s = '0;
        end
        if (wr_ok_s && (word_idx_s == IRQ_EN_IDX)) begin
            irq_en_d = tl.a_data[NumCores-1:0];
        end else begin
            irq_en_d = irq_en_r;
        end
        done_flags_d = (done_flags_r & ~w1c_s) | done_evt_s;
    end

    // Register file and interrupt flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_flags_r <= '0;
            irq_en_r     <= '0;
            irq_r        <= 1'b0;
            boot_addr_r  <= {NumCores{BootAddrDefault}};
        end else begin
            done_flags_r <= done_flags_d;
            irq_en_r     <= irq_en_d;
            irq_r        <= |(done_flags_d & irq_en_d);
            for (int i = 0; i < NumCores; i++) begin
                if (wr_ok_s && boot_sel_s[i]) begin
                    boot_addr_r[i] <= tl.a_data;
                end
            end
        end
    end

    // Single outstanding response; held until the host takes it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_valid_r  <= 1'b0;
            d_opcode_r <= 3'h0;
            d_size_r   <= 2'h0;
            d_source_r <= 8'h0;
            d_data_r   <= 32'h0;
            d_error_r  <= 1'b0;
        end else if (accept_s) begin
            d_valid_r  <= 1'b1;
            d_opcode_r <= is_read_s ? TL_ACK_DATA : TL_ACK;
            d_size_r   <= tl.a_size;
            d_source_r <= tl.a_source;
            d_data_r   <= (is_read_s && !err_s) ? rdata_s : 32'h0;
            d_error_r  <= err_s;
        end else if (tl.d_ready) begin
            d_valid_r <= 1'b0;
        end else begin
            d_valid_r <= d_valid_r;
        end
    end

    assign tl.a_ready  = !d_valid_r && !rst_i;
    assign tl.d_valid  = d_valid_r;
    assign tl.d_opcode = d_opcode_r;
    assign tl.d_size   = d_size_r;
    assign tl.d_source = d_source_r;
    assign tl.d_data   = d_data_r;
    assign tl.d_error  = d_error_r;
    assign tl.d_user   = {intg_code({18'h0, d_opcode_r, d_size_r, d_source_r, d_error_r}),
                          intg_code(d_data_r)};

    assign core_boot_addr_o = boot_addr_r;
    assign irq_o            = irq_r;

endmodule

// File: tb/tb_vicuna_cluster_ctrl.sv
// Directed self-checking bench for vicuna_cluster_ctrl (2 cores, 16-cycle hold).
module tb_vicuna_cluster_ctrl;
    import vicuna_cluster_ctrl_pkg::*;

    localparam int unsigned NC       = 2;
    localparam int unsigned HOLD     = 16;
    localparam logic [31:0] BOOT_DEF = 32'h8000_0000;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NC-1:0]       core_rst_n;
    logic [NC-1:0][31:0] boot_addr;
    logic [NC-1:0]       core_done = '0;
    logic                irq;
    int                  errors = 0;
    int                  checks = 0;
    int                  cyc = 0;
    int                  acc_cyc = 0;
    logic [31:0]         rd_data;
    logic                rd_err;

    vicuna_cluster_ctrl_if tl();

    vicuna_cluster_ctrl #(
        .NumCores(NC), .ResetHoldCycles(HOLD), .BootAddrDefault(BOOT_DEF)
    ) dut (
        .clk_i(clk), .rst_i(rst), .tl(tl), .core_rst_no(core_rst_n),
        .core_boot_addr_o(boot_addr), .core_done_i(core_done), .irq_o(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tl_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mask);
        int n;
        logic [7:0] src;
        logic [2:0] exp_op;
        src = tl.a_source + 8'd1;
        exp_op = (op == TL_GET) ? TL_ACK_DATA : TL_ACK;
        tl.a_valid = 1'b1; tl.a_opcode = op; tl.a_address = addr; tl.a_data = data;
        tl.a_mask = mask; tl.a_source = src; tl.a_size = 2'd2; tl.d_ready = 1'b1;
        n = 0;
        while (tl.a_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        acc_cyc = cyc;
        tl.a_valid = 1'b0;
        n = 0;
        while (tl.d_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        rd_data = tl.d_data;
        rd_err = tl.d_error;
        checks++;
        if (tl.d_valid !== 1'b1 || tl.d_source !== src || tl.d_size !== 2'd2 || tl.d_opcode !== exp_op) begin
            errors++;
            $display("FAIL tl_rsp addr=%h: valid=%b src=%h size=%h op=%h required valid=1 src=%h size=2 op=%h",
                     addr, tl.d_valid, tl.d_source, tl.d_size, tl.d_opcode, src, exp_op);
        end
        @(posedge clk); #1;
    endtask

    task automatic tl_write(input logic [31:0] addr, input logic [31:0] data);
        tl_access(TL_PUT_FULL, addr, data, 4'hF);
    endtask

    task automatic tl_read(input logic [31:0] addr);
        tl_access(TL_GET, addr, 32'h0, 4'hF);
    endtask

    task automatic wait_rise(input int idx);
        int n = 0;
        while (core_rst_n[idx] !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
        checks++;
        if (core_rst_n[idx] !== 1'b1) begin errors++; $display("FAIL rise_timeout core%0d: got %b expected 1", idx, core_rst_n[idx]); end
    endtask

    task automatic pulse_done(input logic [NC-1:0] v);
        core_done = v; @(posedge clk); #1; core_done = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tl.a_ready !== 1'b0) begin errors++; $display("FAIL a_ready_in_reset: got %b expected 0", tl.a_ready); end
        rst = 1'b0;
        checks++; if (tl.d_valid !== 1'b0 || core_rst_n !== 2'b00 || irq !== 1'b0) begin errors++;
            $display("FAIL reset_outputs: d_valid=%b core_rst_n=%b irq=%b expected 0,00,0", tl.d_valid, core_rst_n, irq); end
        tl_read(32'h4);
        checks++; if (rd_data !== 32'h0 || rd_err !== 1'b0) begin errors++; $display("FAIL status_reset: got %h err=%b expected 0", rd_data, rd_err); end
        tl_read(32'h10);
        checks++; if (rd_data !== BOOT_DEF) begin errors++; $display("FAIL boot0_reset: got %h expected %h", rd_data, BOOT_DEF); end
        checks++; if (boot_addr[1] !== BOOT_DEF) begin errors++; $display("FAIL boot1_port_reset: got %h expected %h", boot_addr[1], BOOT_DEF); end
    endtask

    task automatic test_release();
        int start;
        tl_write(32'h14, 32'h0001_0000);
        checks++; if (rd_err !== 1'b0 || boot_addr[1] !== 32'h0001_0000) begin errors++;
            $display("FAIL boot1_write: err=%b port=%h expected 0,00010000", rd_err, boot_addr[1]); end
        tl_write(32'h0, 32'h2);
        start = acc_cyc;
        wait_rise(1);
        checks++; if (cyc - start !== HOLD + 1) begin errors++; $display("FAIL release_latency: got %0d expected %0d", cyc - start, HOLD + 1); end
        checks++; if (core_rst_n[0] !== 1'b0) begin errors++; $display("FAIL core0_held: got %b expected 0", core_rst_n[0]); end
        tl_read(32'h4);
        checks++; if (rd_data !== 32'h8) begin errors++; $display("FAIL status_run1: got %h expected 8", rd_data); end
    endtask

    task automatic test_done();
        tl_write(32'h0, 32'h1);
        tl_write(32'hC, 32'h1);
        wait_rise(0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_done: got %b expected 0", irq); end
        pulse_done(2'b01);
        checks++; if (irq !== 1'b1 || core_rst_n[0] !== 1'b1) begin errors++;
            $display("FAIL done_edge: irq=%b rst_n0=%b expected 1,1", irq, core_rst_n[0]); end
        @(posedge clk); #1;
        checks++; if (core_rst_n !== 2'b10) begin errors++; $display("FAIL done_reset_drop: got %b expected 10", core_rst_n); end
        tl_read(32'h8);
        checks++; if (rd_data !== 32'h1) begin errors++; $display("FAIL done_flags_set: got %h expected 1", rd_data); end
        tl_read(32'h4);
        checks++; if (rd_data !== 32'hB) begin errors++; $display("FAIL status_done0: got %h expected b", rd_data); end
        tl_write(32'h8, 32'h1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_w1c: got %b expected 0", irq); end
        pulse_done(2'b01);
        tl_read(32'h8);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL done_outside_run: got %h expected 0", rd_data); end
    endtask

    task automatic test_errors();
        tl_write(32'h14, 32'hDEAD_BEEF);
        checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL boot_busy_err: got %b expected 1", rd_err); end
        tl_read(32'h14);
        checks++; if (rd_data !== 32'h0001_0000 || rd_err !== 1'b0) begin errors++; $display("FAIL boot_busy_keep: got %h expected 00010000", rd_data); end
        tl_access(TL_PUT_PARTIAL, 32'hC, 32'h0, 4'h3);
        checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL mask_err: got %b expected 1", rd_err); end
        tl_read(32'hC);
        checks++; if (rd_data !== 32'h1) begin errors++; $display("FAIL mask_no_effect: got %h expected 1", rd_data); end
        tl_read(32'h40);
        checks++; if (rd_err !== 1'b1 || rd_data !== 32'h0) begin errors++; $display("FAIL unmapped: err=%b data=%h expected 1,0", rd_err, rd_data); end
        tl_write(32'h10, 32'h0000_2000);
        checks++; if (rd_err !== 1'b0 || boot_addr[0] !== 32'h2000) begin errors++;
            $display("FAIL boot0_done_write: err=%b port=%h expected 0,2000", rd_err, boot_addr[0]); end
        tl_read(32'h0);
        checks++; if (rd_data !== 32'h0 || rd_err !== 1'b0) begin errors++; $display("FAIL ctrl_reads_zero: got %h expected 0", rd_data); end
    endtask

    task automatic test_start_stop();
        int high = 0;
        tl_write(32'h0, 32'h0001_0001);
        tl_read(32'h4);
        checks++; if (rd_data !== 32'h8) begin errors++; $display("FAIL start_stop_same: got %h expected 8", rd_data); end
        tl_write(32'h0, 32'h1);
        tl_read(32'h4);
        checks++; if (rd_data !== 32'h9) begin errors++; $display("FAIL status_hold: got %h expected 9", rd_data); end
        tl_write(32'h0, 32'h0001_0000);
        for (int i = 0; i < 30; i++) begin
            if (core_rst_n[0] === 1'b1) high++;
            @(posedge clk); #1;
        end
        checks++; if (high !== 0) begin errors++; $display("FAIL stop_in_hold: rst_n0 high %0d cycles expected 0", high); end
        core_done = 2'b10;
        tl_write(32'h0, 32'h0002_0000);
        core_done = '0;
        checks++; if (core_rst_n !== 2'b00) begin errors++; $display("FAIL stop_run: got %b expected 00", core_rst_n); end
        tl_read(32'h8);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL stop_vs_done: got %h expected 0", rd_data); end
        tl_read(32'h4);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL status_all_idle: got %h expected 0", rd_data); end
    endtask

    task automatic test_w1c_race();
        tl_write(32'h0, 32'h2);
        wait_rise(1);
        pulse_done(2'b10);
        tl_read(32'h8);
        checks++; if (rd_data !== 32'h2) begin errors++; $display("FAIL done1_set: got %h expected 2", rd_data); end
        tl_write(32'h0, 32'h2);
        wait_rise(1);
        core_done = 2'b10;
        tl_write(32'h8, 32'h2);
        core_done = '0;
        tl_read(32'h8);
        checks++; if (rd_data !== 32'h2 || irq !== 1'b0) begin errors++; $display("FAIL w1c_vs_done: flags=%h irq=%b expected 2,0", rd_data, irq); end
        tl_write(32'hC, 32'h3);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_enable1: got %b expected 1", irq); end
    endtask

    task automatic test_back_to_back();
        tl.a_valid = 1'b1; tl.a_opcode = TL_GET; tl.a_address = 32'h4; tl.a_mask = 4'hF; tl.d_ready = 1'b0;
        @(posedge clk); #1;
        tl.a_address = 32'hC;
        for (int i = 0; i < 5; i++) begin
            checks++; if (tl.d_valid !== 1'b1 || tl.a_ready !== 1'b0 || tl.d_data !== 32'hC) begin errors++;
                $display("FAIL stall_%0d: d_valid=%b a_ready=%b data=%h expected 1,0,c", i, tl.d_valid, tl.a_ready, tl.d_data); end
            @(posedge clk); #1;
        end
        tl.d_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (tl.d_valid !== 1'b0 || tl.a_ready !== 1'b1) begin errors++;
            $display("FAIL handshake: d_valid=%b a_ready=%b expected 0,1", tl.d_valid, tl.a_ready); end
        @(posedge clk); #1;
        tl.a_valid = 1'b0;
        checks++; if (tl.d_valid !== 1'b1 || tl.d_data !== 32'h3) begin errors++;
            $display("FAIL second_req: d_valid=%b data=%h expected 1,3", tl.d_valid, tl.d_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        tl_write(32'h0, 32'h1);
        tl.a_valid = 1'b1; tl.a_opcode = TL_GET; tl.a_address = 32'h4; tl.d_ready = 1'b0;
        @(posedge clk); #1;
        tl.a_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (tl.d_valid !== 1'b0 || tl.a_ready !== 1'b0) begin errors++;
            $display("FAIL reset_mid_rsp: d_valid=%b a_ready=%b expected 0,0", tl.d_valid, tl.a_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (core_rst_n !== 2'b00 || irq !== 1'b0 || boot_addr[0] !== BOOT_DEF) begin errors++;
            $display("FAIL reset_mid_state: rst_n=%b irq=%b boot0=%h expected 00,0,%h", core_rst_n, irq, boot_addr[0], BOOT_DEF); end
        tl_read(32'h4);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_mid_status: got %h expected 0", rd_data); end
        tl_read(32'h8);
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_mid_flags: got %h expected 0", rd_data); end
    endtask

    initial begin
        tl.a_valid = 1'b0; tl.a_opcode = TL_GET; tl.a_size = 2'd2; tl.a_source = 8'h0;
        tl.a_address = 32'h0; tl.a_mask = 4'hF; tl.a_data = 32'h0; tl.d_ready = 1'b1;
        test_reset();
        test_release();
        test_done();
        test_errors();
        test_start_stop();
        test_w1c_race();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
